// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: data-memory request/ack bus between the MEM-stage sequencer and data memory
interface mem_access_ctrl_if #(
    parameter int DATA_W = 32
) ();
    logic              dmem_req;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ack;
    logic [DATA_W-1:0] dmem_rdata;
    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );
    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store sequencer with pipeline freeze, bubble insertion and access timeout
module mem_access_ctrl #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mem_read_M,
    input  logic                mem_write_M,
    input  logic                OverflowM,
    input  logic [DATA_W-1:0]   alu_out_M,
    input  logic [DATA_W-1:0]   wdata_M,
    mem_access_ctrl_if.master   dmem,
    output logic                stall,
    output logic                bubble_W,
    output logic [DATA_W-1:0]   memory_data_out,
    output logic                timeout_err
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t            r_state;
    logic              r_req;
    logic              r_we;
    logic [DATA_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_mdo;
    logic              r_err;
    logic [15:0]       r_cnt;
    logic              w_access;
    assign w_access = (mem_read_M | mem_write_M) & ~OverflowM;
    // Gated by rst_n so the freeze releases immediately when reset is asserted
    assign stall    = rst_n & ((r_state == IDLE & w_access) | r_state == WAIT);
    assign bubble_W = stall;
    assign dmem.dmem_req   = r_req;
    assign dmem.dmem_we    = r_we;
    assign dmem.dmem_addr  = r_addr;
    assign dmem.dmem_wdata = r_wdata;
    assign memory_data_out = r_mdo;
    assign timeout_err     = r_err;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_mdo   <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_access) begin
                    r_state <= WAIT;
                    r_req   <= 1'b1;
                    r_we    <= mem_write_M;
                    r_addr  <= alu_out_M;
                    r_wdata <= wdata_M;
                    r_cnt   <= '0;
                end
                WAIT: if (dmem.dmem_ack) begin
                    r_state <= RESP;
                    r_req   <= 1'b0;
                    if (!r_we) r_mdo <= dmem.dmem_rdata;
                end else if (r_cnt == 16'(TIMEOUT - 1)) begin
                    r_state <= RESP;
                    r_req   <= 1'b0;
                    r_mdo   <= '0;
                    r_err   <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 16'd1;
                end
                RESP: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed checks of the MEM-stage sequencer against hand-computed cycle counts and data
module tb_mem_access_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd, wr, ov;
    logic [31:0] addr, wd;
    logic        stall, bubble;
    logic [31:0] mdo;
    logic        terr;
    int          n_checks = 0;
    int          n_errors = 0;
    int          ns, nr, first;
    logic [31:0] r_mdo;
    logic        r_busy;

    always #5 clk = ~clk;

    mem_access_ctrl_if #(.DATA_W(32)) bus ();

    mem_access_ctrl #(.DATA_W(32), .TIMEOUT(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem_read_M      (rd),
        .mem_write_M     (wr),
        .OverflowM       (ov),
        .alu_out_M       (addr),
        .wdata_M         (wd),
        .dmem            (bus),
        .stall           (stall),
        .bubble_W        (bubble),
        .memory_data_out (mdo),
        .timeout_err     (terr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Presents one instruction at a negedge and runs it until it leaves MEM.
    // ack_at = n acks on the n-th request cycle; 0 never acks.
    task automatic access(input logic r, input logic w, input logic o,
                          input logic [31:0] a, input logic [31:0] d, input logic [31:0] rdat,
                          input int ack_at, output int n_stall, output int n_req, output int first_req,
                          output logic [31:0] resp_mdo, output logic resp_busy);
        rd = r; wr = w; ov = o; addr = a; wd = d; bus.dmem_rdata = rdat;
        n_stall = 0; n_req = 0; first_req = -1; resp_mdo = '0; resp_busy = 1'b1;
        for (int c = 0; c < 400; c++) begin
            #1;
            bus.dmem_ack = 1'b0;
            if (bus.dmem_req) begin
                if (first_req < 0) first_req = c;
                n_req++;
                check("req_addr", bus.dmem_addr, a);
                check("req_we", 32'(bus.dmem_we), 32'(w));
                if (w) check("req_wdata", bus.dmem_wdata, d);
                if (ack_at != 0 && n_req == ack_at) bus.dmem_ack = 1'b1;
            end
            if (!stall) begin
                resp_mdo  = mdo;
                resp_busy = bus.dmem_req | bubble;
                @(negedge clk);
                return;
            end
            n_stall++;
            @(negedge clk);
        end
        n_checks++;
        n_errors++;
        $display("FAIL stall_bound: stall still 1 after 400 cycles");
    endtask

    initial begin
        rd = 0; wr = 0; ov = 0; addr = '0; wd = '0;
        bus.dmem_ack = 0; bus.dmem_rdata = '0;
        #2;
        check("rst_req", 32'(bus.dmem_req), 0);
        check("rst_we", 32'(bus.dmem_we), 0);
        check("rst_addr", bus.dmem_addr, 0);
        check("rst_wdata", bus.dmem_wdata, 0);
        check("rst_mdo", mdo, 0);
        check("rst_terr", 32'(terr), 0);
        check("rst_stall", 32'(stall), 0);
        check("rst_bubble", 32'(bubble), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;

        access(0, 0, 0, 32'h5, 32'h0, 32'h0, 1, ns, nr, first, r_mdo, r_busy);
        check("alu_stall", ns, 0);
        check("alu_req", nr, 0);

        access(1, 0, 0, 32'h10, 32'h0, 32'hDEADBEEF, 1, ns, nr, first, r_mdo, r_busy);
        check("ld_stall", ns, 2);
        check("ld_req", nr, 1);
        check("ld_mdo", r_mdo, 32'hDEADBEEF);
        check("ld_resp_idle", 32'(r_busy), 0);

        access(0, 1, 0, 32'h20, 32'h12345678, 32'hFFFFFFFF, 5, ns, nr, first, r_mdo, r_busy);
        check("st_stall", ns, 6);
        check("st_req", nr, 5);
        check("st_mdo", r_mdo, 32'hDEADBEEF);

        access(1, 1, 0, 32'h24, 32'hA5A5A5A5, 32'h11111111, 1, ns, nr, first, r_mdo, r_busy);
        check("rw_stall", ns, 2);
        check("rw_mdo", r_mdo, 32'hDEADBEEF);

        access(1, 0, 1, 32'h30, 32'h0, 32'h22222222, 1, ns, nr, first, r_mdo, r_busy);
        check("ovf_stall", ns, 0);
        check("ovf_req", nr, 0);
        access(0, 1, 1, 32'h34, 32'h9, 32'h0, 1, ns, nr, first, r_mdo, r_busy);
        check("ovf_st_req", nr, 0);

        bus.dmem_ack = 1; rd = 0; wr = 0; ov = 0; bus.dmem_rdata = 32'h33333333;
        @(negedge clk);
        #1;
        check("idle_ack_req", 32'(bus.dmem_req), 0);
        check("idle_ack_mdo", mdo, 32'hDEADBEEF);
        bus.dmem_ack = 0;
        @(negedge clk);

        access(1, 0, 0, 32'h40, 32'h0, 32'h01020304, 1, ns, nr, first, r_mdo, r_busy);
        check("b2b1_mdo", r_mdo, 32'h01020304);
        access(1, 0, 0, 32'h44, 32'h0, 32'h05060708, 1, ns, nr, first, r_mdo, r_busy);
        check("b2b2_first_req", first, 1);
        check("b2b2_stall", ns, 2);
        check("b2b2_mdo", r_mdo, 32'h05060708);

        access(1, 0, 0, 32'h50, 32'h0, 32'hCAFEF00D, 8, ns, nr, first, r_mdo, r_busy);
        check("tie_req", nr, 8);
        check("tie_mdo", r_mdo, 32'hCAFEF00D);
        check("tie_terr", 32'(terr), 0);

        access(1, 0, 0, 32'h60, 32'h0, 32'h44444444, 0, ns, nr, first, r_mdo, r_busy);
        check("to_req", nr, 8);
        check("to_stall", ns, 9);
        check("to_mdo", r_mdo, 0);
        check("to_terr", 32'(terr), 1);

        access(0, 0, 0, 32'h0, 32'h0, 32'h0, 1, ns, nr, first, r_mdo, r_busy);
        check("to_resume_stall", ns, 0);
        check("to_sticky", 32'(terr), 1);

        access(1, 0, 0, 32'h70, 32'h0, 32'h55555555, 2, ns, nr, first, r_mdo, r_busy);
        check("post_to_mdo", r_mdo, 32'h55555555);
        check("post_to_sticky", 32'(terr), 1);

        rd = 1; wr = 0; addr = 32'h80; bus.dmem_ack = 0;
        @(negedge clk);
        #1;
        check("mid_req", 32'(bus.dmem_req), 1);
        rst_n = 0;
        #1;
        check("mid_rst_req", 32'(bus.dmem_req), 0);
        check("mid_rst_stall", 32'(stall), 0);
        check("mid_rst_terr", 32'(terr), 0);
        check("mid_rst_mdo", mdo, 0);
        rd = 0;
        @(negedge clk);
        rst_n = 1;
        #1;
        check("post_rst_stall", 32'(stall), 0);
        @(negedge clk);
        #1;
        check("post_rst_req", 32'(bus.dmem_req), 0);
        @(negedge clk);

        access(1, 0, 0, 32'h90, 32'h0, 32'h0BADF00D, 2, ns, nr, first, r_mdo, r_busy);
        check("post_rst_ld_stall", ns, 3);
        check("post_rst_ld_mdo", r_mdo, 32'h0BADF00D);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
